// File: rtl/rx_stream_checker_if.sv
// Record stream between rx_streamer and its downstream checker: data/valid,
// lost-frame pulse, per-frame latency strobe and the data request back upstream.
interface rx_stream_checker_if #(
  parameter int g_data_width    = 64,
  parameter int g_latency_width = 28
);
  logic [g_data_width-1:0]    rx_data;
  logic                       rx_valid;
  logic                       rx_lost;
  logic [g_latency_width-1:0] rx_latency;
  logic                       rx_latency_valid;
  logic                       rx_dreq;

  modport master (
    output rx_data, rx_valid, rx_lost, rx_latency, rx_latency_valid,
    input  rx_dreq
  );

  modport slave (
    input  rx_data, rx_valid, rx_lost, rx_latency, rx_latency_valid,
    output rx_dreq
  );
endinterface

// File: rtl/rx_stream_checker.sv
// Link-quality monitor behind rx_streamer: verifies records form a counting
// sequence, counts good/bad/lost events and gathers frame latency statistics.
module rx_stream_checker #(
  parameter int g_data_width    = 64,
  parameter int g_latency_width = 28,
  parameter int g_count_width   = 32,
  parameter int g_sum_width     = 48
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       dreq_en_i,
  rx_stream_checker_if.slave         rx,
  output logic                       seq_err_o,
  output logic [g_count_width-1:0]   good_cnt_o,
  output logic [g_count_width-1:0]   err_cnt_o,
  output logic [g_count_width-1:0]   lost_cnt_o,
  output logic [g_data_width-1:0]    last_bad_o,
  output logic [g_latency_width-1:0] lat_min_o,
  output logic [g_latency_width-1:0] lat_max_o,
  output logic [g_sum_width-1:0]     lat_sum_o,
  output logic [g_count_width-1:0]   lat_cnt_o
);

  localparam logic [g_data_width-1:0]  DATA_ONE = {{(g_data_width-1){1'b0}}, 1'b1};
  localparam logic [g_count_width-1:0] CNT_ONE  = {{(g_count_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [g_data_width-1:0]   expected;
  logic                      resync;

  logic                      active;
  logic                      accept;
  logic                      in_seq;
  logic                      resync_eff;
  logic                      count_good;
  logic                      count_err;
  logic [g_sum_width:0]      sum_ext;

  function automatic logic [g_count_width-1:0] sat_inc(input logic [g_count_width-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A lost pulse arriving with a record makes that very record the resync point.
  always_comb begin
    state_next = state;
    active     = (state != IDLE);
    accept     = active & rx.rx_valid;
    in_seq     = (rx.rx_data == expected);
    resync_eff = resync | rx.rx_lost;
    count_good = accept & ((state == SYNC) | in_seq);
    count_err  = accept & (state == RUN) & ~in_seq & ~resync_eff;
    sum_ext    = {1'b0, lat_sum_o}
               + {{(g_sum_width + 1 - g_latency_width){1'b0}}, rx.rx_latency};

    if (clear_i) begin
      state_next = enable_i ? SYNC : IDLE;
    end else if (!enable_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SYNC;
        SYNC:    state_next = rx.rx_valid ? RUN : SYNC;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rx.rx_dreq <= 1'b0;
      seq_err_o  <= 1'b0;
      expected   <= '0;
      resync     <= 1'b0;
      good_cnt_o <= '0;
      err_cnt_o  <= '0;
      lost_cnt_o <= '0;
      last_bad_o <= '0;
      lat_min_o  <= '1;
      lat_max_o  <= '0;
      lat_sum_o  <= '0;
      lat_cnt_o  <= '0;
    end else begin
      rx.rx_dreq <= active & enable_i & dreq_en_i;
      seq_err_o  <= 1'b0;

      if (clear_i) begin
        expected   <= '0;
        resync     <= 1'b0;
        good_cnt_o <= '0;
        err_cnt_o  <= '0;
        lost_cnt_o <= '0;
        last_bad_o <= '0;
        lat_min_o  <= '1;
        lat_max_o  <= '0;
        lat_sum_o  <= '0;
        lat_cnt_o  <= '0;
      end else begin
        if (active && rx.rx_lost) begin
          lost_cnt_o <= sat_inc(lost_cnt_o);
          resync     <= 1'b1;
        end

        // When in sequence, data+1 equals expected+1, so one update covers every case.
        if (accept) begin
          expected <= rx.rx_data + DATA_ONE;
          resync   <= 1'b0;
        end

        if (count_good) begin
          good_cnt_o <= sat_inc(good_cnt_o);
        end

        if (count_err) begin
          err_cnt_o  <= sat_inc(err_cnt_o);
          last_bad_o <= rx.rx_data;
          seq_err_o  <= 1'b1;
        end

        if (rx.rx_latency_valid) begin
          lat_cnt_o <= sat_inc(lat_cnt_o);
          lat_sum_o <= sum_ext[g_sum_width] ? '1 : sum_ext[g_sum_width-1:0];
          if (rx.rx_latency < lat_min_o) begin
            lat_min_o <= rx.rx_latency;
          end
          if (rx.rx_latency > lat_max_o) begin
            lat_max_o <= rx.rx_latency;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_stream_checker.sv
// Randomized bench for rx_stream_checker; a rule-level model of the sequence
// and latency statistics supplies every expected value.
module tb_rx_stream_checker;

  localparam int DW = 64;
  localparam int LW = 28;
  localparam int CW = 32;
  localparam int SW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enable;
  logic          clear;
  logic          dreq_en;
  logic          seq_err;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] lost_cnt;
  logic [CW-1:0] lat_cnt;
  logic [DW-1:0] last_bad;
  logic [LW-1:0] lat_min;
  logic [LW-1:0] lat_max;
  logic [SW-1:0] lat_sum;

  rx_stream_checker_if #(.g_data_width(DW), .g_latency_width(LW)) bus ();

  rx_stream_checker #(
    .g_data_width(DW), .g_latency_width(LW), .g_count_width(CW), .g_sum_width(SW)
  ) dut (
    .clk_sys_i (clk),
    .rst_i     (rst),
    .enable_i  (enable),
    .clear_i   (clear),
    .dreq_en_i (dreq_en),
    .rx        (bus),
    .seq_err_o (seq_err),
    .good_cnt_o(good_cnt),
    .err_cnt_o (err_cnt),
    .lost_cnt_o(lost_cnt),
    .last_bad_o(last_bad),
    .lat_min_o (lat_min),
    .lat_max_o (lat_max),
    .lat_sum_o (lat_sum),
    .lat_cnt_o (lat_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: what a link monitor should have seen so far.
  bit            m_active;
  bit            m_synced;
  bit            m_resync;
  bit            m_last_pulse;
  logic [DW-1:0] m_expected;
  logic [DW-1:0] m_last_bad;
  int unsigned   m_good;
  int unsigned   m_err;
  int unsigned   m_lost;
  int unsigned   m_pulses;
  int unsigned   obs_pulses;
  logic [LW-1:0] lat_q[$];
  logic [LW-1:0] e_min;
  logic [LW-1:0] e_max;
  logic [SW-1:0] e_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_synced   = 1'b0;
    m_resync   = 1'b0;
    m_expected = '0;
    m_last_bad = '0;
    m_good     = 0;
    m_err      = 0;
    m_lost     = 0;
    lat_q.delete();
  endtask

  task automatic model_event(input bit v, input logic [DW-1:0] d, input bit l);
    m_last_pulse = 1'b0;
    if (!m_active) return;
    if (l) begin
      m_lost++;
      m_resync = 1'b1;
    end
    if (v) begin
      if (!m_synced) m_good++;
      else if (d == m_expected) m_good++;
      else if (!m_resync) begin
        m_err++;
        m_last_bad   = d;
        m_pulses++;
        m_last_pulse = 1'b1;
      end
      m_synced   = 1'b1;
      m_resync   = 1'b0;
      m_expected = d + 64'd1;
    end
  endtask

  task automatic model_lat();
    e_min = '1;
    e_max = '0;
    e_sum = '0;
    foreach (lat_q[i]) begin
      if (lat_q[i] < e_min) e_min = lat_q[i];
      if (lat_q[i] > e_max) e_max = lat_q[i];
      e_sum += SW'(lat_q[i]);
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit l,
                             input bit lv, input logic [LW-1:0] lat);
    bus.rx_valid         = v;
    bus.rx_data          = d;
    bus.rx_lost          = l;
    bus.rx_latency_valid = lv;
    bus.rx_latency       = lat;
    tick();
    bus.rx_valid         = 1'b0;
    bus.rx_lost          = 1'b0;
    bus.rx_latency_valid = 1'b0;
    model_event(v, d, l);
    if (lv) lat_q.push_back(lat);
    if (seq_err) obs_pulses++;
  endtask

  task automatic drive_idle();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic send(input logic [DW-1:0] d);
    drive_cycle(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic do_clear(input bit lv, input logic [LW-1:0] lat);
    clear                = 1'b1;
    bus.rx_valid         = 1'b1;
    bus.rx_data          = 64'h5A5A;
    bus.rx_lost          = 1'b1;
    bus.rx_latency_valid = lv;
    bus.rx_latency       = lat;
    tick();
    clear                = 1'b0;
    bus.rx_valid         = 1'b0;
    bus.rx_lost          = 1'b0;
    bus.rx_latency_valid = 1'b0;
    model_clear();
    m_active = enable;
    if (seq_err) obs_pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0; dreq_en = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_lost = 1'b0;
    bus.rx_latency_valid = 1'b0; bus.rx_latency = '0;
    m_active = 1'b0; m_pulses = 0; obs_pulses = 0;
    model_clear();
    tick(); tick();
    tests_run++; if (bus.rx_dreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dreq: got %0b want 0", bus.rx_dreq); end
    tests_run++; if (seq_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_seq_err: got %0b want 0", seq_err); end
    tests_run++; if (good_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_good: got %0d want 0", good_cnt); end
    tests_run++; if (err_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0d want 0", err_cnt); end
    tests_run++; if (lost_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_lost: got %0d want 0", lost_cnt); end
    tests_run++; if (last_bad !== '0) begin tests_failed++; $display("[TB] FAIL reset_last_bad: got %0h want 0", last_bad); end
    tests_run++; if (lat_min !== {LW{1'b1}}) begin tests_failed++; $display("[TB] FAIL reset_lat_min: got %0h want all ones", lat_min); end
    tests_run++; if (lat_max !== '0 || lat_sum !== '0 || lat_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_lat_stats: got max %0d sum %0d cnt %0d want 0", lat_max, lat_sum, lat_cnt); end
    rst = 1'b0; enable = 1'b1; dreq_en = 1'b1;
    drive_idle();
    m_active = 1'b1;
    tests_run++; if (bus.rx_dreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL dreq_from_idle: got %0b want 0", bus.rx_dreq); end
    drive_idle();
    tests_run++; if (bus.rx_dreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL dreq_in_sync: got %0b want 1", bus.rx_dreq); end
  endtask

  task automatic test_in_sequence();
    int unsigned p0 = obs_pulses;
    for (int i = 0; i < 100; i++) begin
      while ($urandom_range(0, 1) == 0) drive_idle();
      send(64'(i));
    end
    drive_idle();
    tests_run++; if (good_cnt !== m_good || m_good != 100) begin tests_failed++; $display("[TB] FAIL seq_good: got %0d want %0d", good_cnt, m_good); end
    tests_run++; if (err_cnt !== m_err) begin tests_failed++; $display("[TB] FAIL seq_err_cnt: got %0d want %0d", err_cnt, m_err); end
    tests_run++; if (obs_pulses != p0) begin tests_failed++; $display("[TB] FAIL seq_no_pulse: got %0d pulses want 0", obs_pulses - p0); end
  endtask

  task automatic test_seq_error();
    do_clear(1'b0, '0);
    tests_run++; if (good_cnt !== '0 || err_cnt !== '0 || lost_cnt !== '0) begin tests_failed++; $display("[TB] FAIL clear_counters: got %0d/%0d/%0d want 0/0/0", good_cnt, err_cnt, lost_cnt); end
    for (int i = 0; i < 10; i++) send(64'(i));
    send(64'd12);
    tests_run++; if (seq_err !== m_last_pulse) begin tests_failed++; $display("[TB] FAIL bad_pulse: got %0b want %0b", seq_err, m_last_pulse); end
    send(64'd13);
    tests_run++; if (seq_err !== m_last_pulse) begin tests_failed++; $display("[TB] FAIL pulse_width: got %0b want %0b", seq_err, m_last_pulse); end
    drive_idle();
    tests_run++; if (err_cnt !== m_err || m_err != 1) begin tests_failed++; $display("[TB] FAIL bad_err_cnt: got %0d want %0d", err_cnt, m_err); end
    tests_run++; if (last_bad !== m_last_bad) begin tests_failed++; $display("[TB] FAIL bad_last_bad: got %0d want %0d", last_bad, m_last_bad); end
    tests_run++; if (good_cnt !== m_good || m_good != 11) begin tests_failed++; $display("[TB] FAIL bad_good: got %0d want %0d", good_cnt, m_good); end
  endtask

  task automatic test_lost();
    do_clear(1'b0, '0);
    for (int i = 0; i <= 5; i++) send(64'(i));
    drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
    send(64'd9);
    send(64'd10);
    drive_idle();
    tests_run++; if (lost_cnt !== m_lost || m_lost != 1) begin tests_failed++; $display("[TB] FAIL lost_cnt: got %0d want %0d", lost_cnt, m_lost); end
    tests_run++; if (err_cnt !== m_err || m_err != 0) begin tests_failed++; $display("[TB] FAIL lost_err: got %0d want %0d", err_cnt, m_err); end
    tests_run++; if (good_cnt !== m_good || m_good != 7) begin tests_failed++; $display("[TB] FAIL lost_good: got %0d want %0d", good_cnt, m_good); end
  endtask

  task automatic test_wrap();
    do_clear(1'b0, '0);
    send(64'hFFFF_FFFF_FFFF_FFFE);
    send(64'hFFFF_FFFF_FFFF_FFFF);
    send(64'h0);
    send(64'h1);
    drive_idle();
    tests_run++; if (good_cnt !== m_good || m_good != 4) begin tests_failed++; $display("[TB] FAIL wrap_good: got %0d want %0d", good_cnt, m_good); end
    tests_run++; if (err_cnt !== m_err) begin tests_failed++; $display("[TB] FAIL wrap_err: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_latency();
    logic [LW-1:0] vals[3] = '{28'd100, 28'd40, 28'd250};
    do_clear(1'b0, '0);
    foreach (vals[i]) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1, vals[i]);
      if ($urandom_range(0, 1) == 1) drive_idle();
    end
    model_lat();
    tests_run++; if (lat_min !== e_min || e_min != 40) begin tests_failed++; $display("[TB] FAIL lat_min: got %0d want %0d", lat_min, e_min); end
    tests_run++; if (lat_max !== e_max || e_max != 250) begin tests_failed++; $display("[TB] FAIL lat_max: got %0d want %0d", lat_max, e_max); end
    tests_run++; if (lat_sum !== e_sum || e_sum != 390) begin tests_failed++; $display("[TB] FAIL lat_sum: got %0d want %0d", lat_sum, e_sum); end
    tests_run++; if (lat_cnt !== CW'(lat_q.size())) begin tests_failed++; $display("[TB] FAIL lat_cnt: got %0d want %0d", lat_cnt, lat_q.size()); end
    do_clear(1'b1, 28'd10);
    model_lat();
    tests_run++; if (lat_cnt !== '0 || lat_min !== e_min) begin tests_failed++; $display("[TB] FAIL lat_clear: got cnt %0d min %0h want 0 and %0h", lat_cnt, lat_min, e_min); end
    tests_run++; if (lat_max !== e_max || lat_sum !== e_sum) begin tests_failed++; $display("[TB] FAIL lat_clear_maxsum: got %0d/%0d want %0d/%0d", lat_max, lat_sum, e_max, e_sum); end
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] src = {$urandom, $urandom};
    do_clear(1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      bit            v  = ($urandom_range(0, 1) == 1);
      bit            l  = ($urandom_range(0, 15) == 0);
      bit            lv = ($urandom_range(0, 3) == 0);
      logic [LW-1:0] lat = LW'($urandom);
      if (v && $urandom_range(0, 7) == 0) src = {$urandom, $urandom};
      drive_cycle(v, src, l, lv, lat);
      if (v) src = src + 64'd1;
    end
    drive_idle();
    model_lat();
    tests_run++; if (good_cnt !== m_good) begin tests_failed++; $display("[TB] FAIL rand_good: got %0d want %0d", good_cnt, m_good); end
    tests_run++; if (err_cnt !== m_err) begin tests_failed++; $display("[TB] FAIL rand_err: got %0d want %0d", err_cnt, m_err); end
    tests_run++; if (lost_cnt !== m_lost) begin tests_failed++; $display("[TB] FAIL rand_lost: got %0d want %0d", lost_cnt, m_lost); end
    tests_run++; if (last_bad !== m_last_bad) begin tests_failed++; $display("[TB] FAIL rand_last_bad: got %0h want %0h", last_bad, m_last_bad); end
    tests_run++; if (obs_pulses != m_pulses) begin tests_failed++; $display("[TB] FAIL rand_pulses: got %0d want %0d", obs_pulses, m_pulses); end
    tests_run++; if (lat_cnt !== CW'(lat_q.size()) || lat_sum !== e_sum) begin tests_failed++; $display("[TB] FAIL rand_lat_cnt_sum: got %0d/%0d want %0d/%0d", lat_cnt, lat_sum, lat_q.size(), e_sum); end
    tests_run++; if (lat_min !== e_min || lat_max !== e_max) begin tests_failed++; $display("[TB] FAIL rand_lat_minmax: got %0d/%0d want %0d/%0d", lat_min, lat_max, e_min, e_max); end
  endtask

  task automatic test_dreq_enable();
    bit            dreq_seen = 1'b0;
    int unsigned   held;
    logic [DW-1:0] base = {$urandom, $urandom};
    do_clear(1'b0, '0);
    send(base);
    dreq_en = 1'b0;
    drive_idle();
    tests_run++; if (bus.rx_dreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL dreq_drop: got %0b want 0", bus.rx_dreq); end
    send(base + 64'd1);
    for (int i = 0; i < 19; i++) begin
      drive_idle();
      if (bus.rx_dreq !== 1'b0) dreq_seen = 1'b1;
    end
    tests_run++; if (dreq_seen) begin tests_failed++; $display("[TB] FAIL dreq_held_low: got 1 want 0"); end
    tests_run++; if (good_cnt !== m_good || m_good != 2) begin tests_failed++; $display("[TB] FAIL late_record: got %0d want %0d", good_cnt, m_good); end
    dreq_en = 1'b1;
    drive_idle();
    tests_run++; if (bus.rx_dreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL dreq_restore: got %0b want 1", bus.rx_dreq); end
    enable = 1'b0;
    drive_idle();
    m_active = 1'b0;
    m_synced = 1'b0;
    tests_run++; if (bus.rx_dreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL dreq_disable: got %0b want 0", bus.rx_dreq); end
    held = m_good;
    send(base + 64'd2);
    send(64'hDEAD);
    drive_idle();
    tests_run++; if (good_cnt !== CW'(held) || err_cnt !== m_err) begin tests_failed++; $display("[TB] FAIL idle_hold: got %0d/%0d want %0d/%0d", good_cnt, err_cnt, held, m_err); end
    enable = 1'b1;
    drive_idle();
    m_active = 1'b1;
    send(64'd500);
    send(64'd501);
    drive_idle();
    tests_run++; if (good_cnt !== m_good || err_cnt !== m_err) begin tests_failed++; $display("[TB] FAIL resync_after_enable: got %0d/%0d want %0d/%0d", good_cnt, err_cnt, m_good, m_err); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 64'(i * 3), 1'b0, 1'b1, LW'(i + 7));
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_latency_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_latency_valid = 1'b0;
    tests_run++; if (good_cnt !== '0 || err_cnt !== '0 || lost_cnt !== '0 || lat_cnt !== '0) begin tests_failed++; $display("[TB] FAIL rst_counters: got %0d/%0d/%0d/%0d want 0", good_cnt, err_cnt, lost_cnt, lat_cnt); end
    tests_run++; if (bus.rx_dreq !== 1'b0 || seq_err !== 1'b0 || last_bad !== '0) begin tests_failed++; $display("[TB] FAIL rst_outputs: got dreq %0b seq_err %0b last_bad %0h want 0", bus.rx_dreq, seq_err, last_bad); end
    tests_run++; if (lat_min !== {LW{1'b1}} || lat_max !== '0 || lat_sum !== '0) begin tests_failed++; $display("[TB] FAIL rst_lat: got %0h/%0d/%0d want all ones/0/0", lat_min, lat_max, lat_sum); end
    rst = 1'b0;
    model_clear();
    m_active = 1'b0;
    drive_idle();
    tests_run++; if (bus.rx_dreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_release_dreq: got %0b want 0", bus.rx_dreq); end
  endtask

  initial begin
    test_reset();
    test_in_sequence();
    test_seq_error();
    test_lost();
    test_wrap();
    test_latency();
    test_random_stream();
    test_dreq_enable();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
